// File: rtl/stream_sync_pkg.sv
// -----------------------------------------------------------------------------
// stream_sync_pkg
// Shared definitions for the stream_sync path:
//   - test pattern codes (PAT_*)
//   - sensor_timing_gen FSM state encoding (gen_state_e)
//   - LFSR seed and the step function for the RANDOM test pattern
// -----------------------------------------------------------------------------
package stream_sync_pkg;

  localparam logic [1:0] PAT_PIX_INC   = 2'd0;
  localparam logic [1:0] PAT_LINE_INC  = 2'd1;
  localparam logic [1:0] PAT_FRAME_INC = 2'd2;
  localparam logic [1:0] PAT_RANDOM    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_LINE   = 3'd2,
    ST_HBLANK = 3'd3,
    ST_TAIL   = 3'd4,
    ST_VBLANK = 3'd5
  } gen_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shifting left.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/sensor_timing_gen_if.sv
// -----------------------------------------------------------------------------
// sensor_timing_gen_if
// Parallel sensor stream bundle as seen by sync_buffer.
//   fval      frame valid
//   lval      line valid
//   pix_data  CHANNEL_NUM pixels per beat, channel 0 in the LSBs
//   frame_cnt completed frames, wraps at 0xFFFF
// Modports: master (generator side), slave (consumer side).
// -----------------------------------------------------------------------------
interface sensor_timing_gen_if #(
  parameter int SENSOR_DAT_WIDTH = 10,
  parameter int CHANNEL_NUM      = 4
);
  logic                                  fval;
  logic                                  lval;
  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] pix_data;
  logic [15:0]                           frame_cnt;

  modport master (output fval, lval, pix_data, frame_cnt);
  modport slave  (input  fval, lval, pix_data, frame_cnt);
endinterface

// File: rtl/sensor_pattern_src.sv
// -----------------------------------------------------------------------------
// sensor_pattern_src
// Registered test-pattern generator for sensor_timing_gen.
// Ports:
//   clk, rst_n    pixel clock, async active-low reset
//   lval_i        current beat is a line beat (state-time, one cycle ahead
//                 of the registered stream outputs)
//   pattern_i     pattern code (PAT_*)
//   pix_cnt_i     beat index within the line
//   line_i        line index within the frame
//   frame_i       completed-frame count
//   pix_data_o    registered pixel word, zero whenever lval_i was low
// Macro SENSOR_TIMING_GEN_RANDOM_EN builds the LFSR and the RANDOM pattern;
// without it, PAT_RANDOM falls back to PIX_INC.
// -----------------------------------------------------------------------------
module sensor_pattern_src
  import stream_sync_pkg::*;
#(
  parameter int SENSOR_DAT_WIDTH = 10,
  parameter int CHANNEL_NUM      = 4,
  parameter int REG_WD           = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    lval_i,
  input  logic [1:0]                              pattern_i,
  input  logic [REG_WD-1:0]                       pix_cnt_i,
  input  logic [REG_WD-1:0]                       line_i,
  input  logic [15:0]                             frame_i,
  output logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] pix_data_o
);
  localparam int W = SENSOR_DAT_WIDTH;

  logic [W*CHANNEL_NUM-1:0] pix_data_d;
  logic [W*CHANNEL_NUM-1:0] pix_data_q;

`ifdef SENSOR_TIMING_GEN_RANDOM_EN
  logic [15:0] lfsr_q;

  // Advances once per line beat, whatever the pattern, so the sequence is a
  // function of beats since reset only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lfsr_q <= LFSR_SEED;
    else if (lval_i) lfsr_q <= lfsr_next(lfsr_q);
  end
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    pix_data_d = '0;
    if (lval_i) begin
      for (int k = 0; k < CHANNEL_NUM; k++) begin
        case (pattern_i)
          PAT_LINE_INC:  pix_data_d[k*W +: W] = W'(line_i);
          PAT_FRAME_INC: pix_data_d[k*W +: W] = W'(frame_i);
`ifdef SENSOR_TIMING_GEN_RANDOM_EN
          PAT_RANDOM:    pix_data_d[k*W +: W] = W'(lfsr_q) ^ W'(k);
`endif
          default:       pix_data_d[k*W +: W] =
                           W'(pix_cnt_i * REG_WD'(CHANNEL_NUM) + REG_WD'(k));
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_data_q <= '0;
    else        pix_data_q <= pix_data_d;
  end

  assign pix_data_o = pix_data_q;

endmodule

// File: rtl/sensor_timing_gen.sv
// -----------------------------------------------------------------------------
// sensor_timing_gen
// Sensor-side fval/lval/pixel transmitter for the stream_sync path; stands in
// for the MT9P031 parallel output.
// Ports:
//   clk_sensor_pix   pixel clock
//   reset_sensor_n   async active-low reset
//   i_enable         run request (level); sampled only in IDLE and at VBLANK end
//   iv_line_active   beats per line H       (0 treated as 1)
//   iv_line_blank    lval-low beats HB      (0 treated as 1)
//   iv_frame_active  lines per frame V      (0 treated as 1)
//   iv_frame_blank   fval-low beats VB      (0 treated as 1)
//   iv_pattern       PAT_* test pattern code
//   stream           master side of sensor_timing_gen_if (fval, lval,
//                    pix_data, frame_cnt), all registered
// Macro SENSOR_TIMING_GEN_RANDOM_EN enables the LFSR RANDOM pattern.
// -----------------------------------------------------------------------------
module sensor_timing_gen
  import stream_sync_pkg::*;
#(
  parameter int SENSOR_DAT_WIDTH = 10,
  parameter int CHANNEL_NUM      = 4,
  parameter int REG_WD           = 32,
  parameter int FVAL_LVAL_GAP    = 3
) (
  input  logic              clk_sensor_pix,
  input  logic              reset_sensor_n,
  input  logic              i_enable,
  input  logic [REG_WD-1:0] iv_line_active,
  input  logic [REG_WD-1:0] iv_line_blank,
  input  logic [REG_WD-1:0] iv_frame_active,
  input  logic [REG_WD-1:0] iv_frame_blank,
  input  logic [1:0]        iv_pattern,
  sensor_timing_gen_if.master stream
);
  localparam logic [REG_WD-1:0] ONE      = REG_WD'(1);
  localparam logic [REG_WD-1:0] GAP_LAST = REG_WD'(FVAL_LVAL_GAP - 1);

  function automatic logic [REG_WD-1:0] clamp1(input logic [REG_WD-1:0] x);
    return (x == '0) ? ONE : x;
  endfunction

  gen_state_e        state_q, state_d;
  logic [REG_WD-1:0] cnt_q, cnt_d;     // beat index inside the current state
  logic [REG_WD-1:0] line_q, line_d;   // line index inside the frame
  logic [REG_WD-1:0] h_q, hb_q, v_q, vb_q;
  logic [1:0]        pat_q;
  logic              latch;
  logic              fval_q, lval_q;
  logic [15:0]       frame_cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + ONE;
    line_d  = line_q;
    latch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (i_enable) begin
          latch   = 1'b1;
          line_d  = '0;
          state_d = ST_LEAD;
        end
      end
      ST_LEAD: if (cnt_q == GAP_LAST) begin
        cnt_d   = '0;
        state_d = ST_LINE;
      end
      ST_LINE: if (cnt_q == h_q - ONE) begin
        cnt_d   = '0;
        state_d = (line_q < v_q - ONE) ? ST_HBLANK : ST_TAIL;
      end
      ST_HBLANK: if (cnt_q == hb_q - ONE) begin
        cnt_d   = '0;
        line_d  = line_q + ONE;
        state_d = ST_LINE;
      end
      ST_TAIL: if (cnt_q == GAP_LAST) begin
        cnt_d   = '0;
        state_d = ST_VBLANK;
      end
      ST_VBLANK: if (cnt_q == vb_q - ONE) begin
        cnt_d = '0;
        if (i_enable) begin
          latch   = 1'b1;
          line_d  = '0;
          state_d = ST_LEAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stream outputs are registered from the current state, so they trail the
  // FSM by one beat; the pattern source is registered on the same edge so data
  // stays aligned with lval. frame_cnt steps on the first VBLANK beat, i.e. on
  // the same edge that drops fval.
  always_ff @(posedge clk_sensor_pix or negedge reset_sensor_n) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_sensor_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      line_q      <= '0;
      h_q         <= ONE;
      hb_q        <= ONE;
      v_q         <= ONE;
      vb_q        <= ONE;
      pat_q       <= PAT_PIX_INC;
      fval_q      <= 1'b0;
      lval_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      if (latch) begin
        h_q   <= clamp1(iv_line_active);
        hb_q  <= clamp1(iv_line_blank);
        v_q   <= clamp1(iv_frame_active);
        vb_q  <= clamp1(iv_frame_blank);
        pat_q <= iv_pattern;
      end
      fval_q <= (state_q inside {ST_LEAD, ST_LINE, ST_HBLANK, ST_TAIL});
      lval_q <= (state_q == ST_LINE);
      if (state_q == ST_VBLANK && cnt_q == '0) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] pix_data;

  sensor_pattern_src #(
    .SENSOR_DAT_WIDTH (SENSOR_DAT_WIDTH),
    .CHANNEL_NUM      (CHANNEL_NUM),
    .REG_WD           (REG_WD)
  ) u_pattern_src (
    .clk        (clk_sensor_pix),
    .rst_n      (reset_sensor_n),
    .lval_i     (state_q == ST_LINE),
    .pattern_i  (pat_q),
    .pix_cnt_i  (cnt_q),
    .line_i     (line_q),
    .frame_i    (frame_cnt_q),
    .pix_data_o (pix_data)
  );

  assign stream.fval      = fval_q;
  assign stream.lval      = lval_q;
  assign stream.pix_data  = pix_data;
  assign stream.frame_cnt = frame_cnt_q;

endmodule

// File: doc/sensor_timing_gen.md
# sensor_timing_gen

Synthesizable sensor-side transmitter for the stream_sync path. It generates the fval/lval/multi-channel pixel stream that sync_buffer consumes, standing in for the MT9P031 parallel output on the board. It runs on the sensor pixel clock and produces frames of programmable geometry and test pattern. It is used for in-system self-test and for benches without the behavioural sensor model.

## Interface
- SENSOR_DAT_WIDTH, 10, bits per channel
- CHANNEL_NUM, 4, pixels per clock beat
- REG_WD, 32, register width
- FVAL_LVAL_GAP, 3, fixed cycles between the fval edge and the nearest lval edge (at least 1)

Ports:
- clk_sensor_pix  in  1  pixel clock
- reset_sensor_n  in  1  asynchronous active-low reset
- i_enable  in  1  run request, level sensitive
- iv_line_active  in  REG_WD  beats per line, H (0 treated as 1)
- iv_line_blank  in  REG_WD  lval-low beats between lines, HB (0 treated as 1)
- iv_frame_active  in  REG_WD  lines per frame, V (0 treated as 1)
- iv_frame_blank  in  REG_WD  fval-low beats after a frame, VB (0 treated as 1)
- iv_pattern  in  2  0 = PIX_INC, 1 = LINE_INC, 2 = FRAME_INC, 3 = RANDOM
- o_fval  out  1  frame valid
- o_lval  out  1  line valid
- ov_pix_data  out  SENSOR_DAT_WIDTH*CHANNEL_NUM  channel 0 in the LSBs
- ov_frame_cnt  out  16  completed frames, wraps at 0xFFFF

## Operation
- FSM states: IDLE, LEAD, LINE, HBLANK, TAIL, VBLANK.
- **IDLE**
  - If i_enable=1, latch H, HB, V, VB and iv_pattern into shadow registers, clear the line and pixel counters, and go to LEAD.
  - Otherwise stay in IDLE.
- **LEAD:** fval=1, lval=0 for FVAL_LVAL_GAP beats, then go to LINE.
- **LINE:** lval=1 for H beats. After the last beat:
  - if the line counter is below V-1, go to HBLANK;
  - otherwise go to TAIL.
- **HBLANK:** lval=0 for HB beats, increment the line counter, then go to LINE.
- **TAIL:** fval=1, lval=0 for FVAL_LVAL_GAP beats, then go to VBLANK. Increment ov_frame_cnt on entry to VBLANK.
- **VBLANK:** fval=0 for VB beats, then:
  - if i_enable=1, re-latch the shadows and go to LEAD;
  - otherwise go to IDLE.
- Deasserting i_enable mid-frame never truncates a frame. The current frame and its VBLANK complete first.
- Register changes mid-frame take effect only at the next latch point.
- Pixel data while lval=1, per channel k (0..CHANNEL_NUM-1), truncated to SENSOR_DAT_WIDTH:
  - PIX_INC: pix_cnt*CHANNEL_NUM + k, where pix_cnt restarts at 0 each line.
  - LINE_INC: line index, same value on all channels.
  - FRAME_INC: ov_frame_cnt, same value on all channels.
  - RANDOM: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 at reset. The LFSR advances once per lval beat. Channel k gets lfsr[SENSOR_DAT_WIDTH-1:0] XOR k.
- ov_pix_data is all zeros whenever lval=0.
- Counters are REG_WD wide. Comparisons use the clamped shadow values.

## Timing
- All outputs are registered. Reset values: o_fval=0, o_lval=0, ov_pix_data=0, ov_frame_cnt=0, FSM in IDLE.
- i_enable sampled high in IDLE at edge n gives o_fval=1 after edge n+1.
- Frame period = 2*FVAL_LVAL_GAP + V*H + (V-1)*HB + VB beats.
- The first lval rises exactly FVAL_LVAL_GAP beats after fval rises.
- fval falls exactly FVAL_LVAL_GAP beats after the last lval falls.
- Reset asserted mid-frame clears all outputs immediately (asynchronous). Operation restarts from IDLE.

## Configuration
- Macro SENSOR_TIMING_GEN_RANDOM_EN.
- Defined: the LFSR and the RANDOM pattern are built in.
- Undefined: no LFSR is built. iv_pattern=3 behaves as PIX_INC.

## Structure
- Shared package stream_sync_pkg holds:
  - the pattern code localparams (PAT_PIX_INC, PAT_LINE_INC, PAT_FRAME_INC, PAT_RANDOM);
  - the FSM state encoding;
  - LFSR_SEED = 16'hACE1.
- Sub-module sensor_pattern_src is natural. It takes the counters, the pattern code and lval, and drives ov_pix_data.

## Test plan
- H=4, HB=2, V=3, VB=5, PIX_INC, CHANNEL_NUM=4:
  - fval high for 22 beats; frame period 27.
  - Line 0 beat 0 data = {3,2,1,0}; beat 3 = {15,14,13,12}.
- Minimum frame, all registers 0 (clamped to 1):
  - fval high 7 beats, one lval beat, period 8.
  - ov_frame_cnt increments every 8 beats.
- i_enable dropped at line 1 of a V=3 frame:
  - the frame completes all 3 lines and VBLANK;
  - the FSM returns to IDLE; no further fval.
- iv_frame_active changed from 3 to 5 mid-frame:
  - the current frame has 3 lval pulses;
  - the next frame has 5.
- Reset pulse mid-line:
  - o_fval, o_lval and data are 0 within the same cycle;
  - after release with i_enable=1, a full frame starts with a 3-beat lead.
- RANDOM pattern with the macro defined:
  - first lval beat channel 0 = 16'hACE1 truncated to 10 bits = 0x0E1, channel 1 = 0x0E0;
  - with the macro undefined the output equals PIX_INC.
